// File: rtl/alu_rr_scheduler.sv
// Round-robin share of one 8-bit ALU between two valid/ready requesters, with a registered tagged response.
// Define ALU_SCHED_STATS_EN to add the per-requester saturating acceptance counters ops0_cnt/ops1_cnt.
module alu_rr_scheduler #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_gt
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]  ops0_cnt,
  output logic [15:0]  ops1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic         last_grant;
  logic [N-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic         cin_q, id_q;

  logic         grant_any, grant_id, in_idle;
  logic         sub_sel;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic [N-1:0] alu_result;
  logic         alu_cout, alu_gt;

  assign in_idle   = (state == IDLE);
  assign grant_any = req0_valid | req1_valid;
  // On a tie the requester that was not granted last wins; otherwise the lone valid one.
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  assign req0_ready = rst_n && in_idle && req0_valid && !grant_id;
  assign req1_ready = rst_n && in_idle && req1_valid &&  grant_id;

  // ALU: subtract is A + ~B + cin, so cin=1 means "no borrow in" and cout=1 means "no borrow out".
  always_comb begin
    sub_sel    = (op_q == 3'b001);
    b_eff      = sub_sel ? ~b_q : b_q;
    sum        = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, cin_q};
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_gt     = 1'b0;
    case (op_q)
      3'b000, 3'b001: begin
        alu_result = sum[N-1:0];
        alu_cout   = sum[N];
      end
      3'b010: alu_result = a_q & b_q;
      3'b011: alu_result = a_q | b_q;
      3'b100: alu_result = a_q ^ b_q;
      3'b101: alu_gt     = (a_q > b_q);
      3'b110: alu_result = {a_q[N-2:0], 1'b0};
      3'b111: alu_result = {b_q[N-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_gt     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cin_q      <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          a_q        <= grant_id ? req1_a   : req0_a;
          b_q        <= grant_id ? req1_b   : req0_b;
          op_q       <= grant_id ? req1_op  : req0_op;
          cin_q      <= grant_id ? req1_cin : req0_cin;
          id_q       <= grant_id;
          last_grant <= grant_id;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_cout   <= alu_cout;
          rsp_gt     <= alu_gt;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0_cnt <= '0;
      ops1_cnt <= '0;
    end else if (in_idle && grant_any) begin
      if (!grant_id && ops0_cnt != 16'hFFFF) ops0_cnt <= ops0_cnt + 16'd1;
      if ( grant_id && ops1_cnt != 16'hFFFF) ops1_cnt <= ops1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: transaction-level model (response queue + grant pointer) checked every cycle,
// directed scenarios pinned with hand-computed literals, then randomized traffic.
module tb_alu_rr_scheduler;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_gt;
  logic [N-1:0] rsp_result;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]  ops0_cnt, ops1_cnt;
`endif

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_gt(rsp_gt)
`ifdef ALU_SCHED_STATS_EN
    , .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt)
`endif
  );

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       cout;
    logic       gt;
  } rsp_t;

  int checks = 0, errors = 0;

  // Bench-side requester and consumer intent, applied to the DUT at each falling edge.
  logic       rst_req = 1'b0;
  logic       rv[2], rcin[2], taken[2];
  logic [7:0] ra[2], rb[2];
  logic [2:0] rop[2];
  logic       rr = 1'b1;

  // Model: queue of responses owed, cycles until the head becomes visible, last-grant pointer.
  rsp_t mq[$];
  int   mdelay = 0;
  logic mlast = 1'b1;
  int   acc_log[$], acc_cyc[$];
  int   cyc = 0;
  int   m_cnt[2];

  logic       o_rdy0, o_rdy1, o_rv, o_id, o_cout, o_gt;
  logic [7:0] o_res;
  logic [15:0] o_cnt0, o_cnt1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic rsp_t ref_alu(input logic id, input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic cin);
    rsp_t r;
    int ai, bi, s;
    ai = int'(a);
    bi = int'(b);
    r.id = id; r.res = 8'h00; r.cout = 1'b0; r.gt = 1'b0;
    case (op)
      3'd0: begin s = ai + bi + int'(cin);         r.res = 8'(s % 256); r.cout = (s > 255); end
      3'd1: begin s = ai + (255 - bi) + int'(cin); r.res = 8'(s % 256); r.cout = (s > 255); end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.gt  = (ai > bi);
      3'd6: r.res = 8'((ai * 2) % 256);
      default: r.res = 8'((bi * 2) % 256);
    endcase
    return r;
  endfunction

  function automatic int grant_of(input logic v0, input logic v1);
    if (v0 && v1) return (mlast == 1'b1) ? 0 : 1;
    if (v1) return 1;
    if (v0) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    mdelay = 0;
    mlast = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic new_op(input int i);
    ra[i]   = 8'($urandom);
    rb[i]   = 8'($urandom);
    rop[i]  = 3'($urandom_range(0, 7));
    rcin[i] = 1'($urandom_range(0, 1));
  endtask

  // One clock: drive at the falling edge, compare 1ns later, advance the model at the rising edge.
  task automatic cycle();
    logic idle, e0, e1, erv;
    int g;
    rsp_t acc;
    @(negedge clk);
    rst_n = rst_req;
    req0_valid = rv[0]; req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0]; req0_cin = rcin[0];
    req1_valid = rv[1]; req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1]; req1_cin = rcin[1];
    rsp_ready = rr;
    if (!rst_req) model_reset();
    #1;
    idle = (mq.size() == 0);
    g    = grant_of(rv[0], rv[1]);
    e0   = rst_req && idle && (g == 0);
    e1   = rst_req && idle && (g == 1);
    erv  = (mq.size() > 0) && (mdelay == 0);
    o_rdy0 = req0_ready; o_rdy1 = req1_ready; o_rv = rsp_valid; o_id = rsp_id;
    o_res = rsp_result; o_cout = rsp_cout; o_gt = rsp_gt;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (erv) begin
      chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
      chk("rsp_result", 32'(rsp_result), 32'(mq[0].res));
      chk("rsp_cout", 32'(rsp_cout), 32'(mq[0].cout));
      chk("rsp_gt", 32'(rsp_gt), 32'(mq[0].gt));
    end
`ifdef ALU_SCHED_STATS_EN
    o_cnt0 = ops0_cnt; o_cnt1 = ops1_cnt;
    chk("ops0_cnt", 32'(ops0_cnt), 32'(m_cnt[0]));
    chk("ops1_cnt", 32'(ops1_cnt), 32'(m_cnt[1]));
`else
    o_cnt0 = '0; o_cnt1 = '0;
`endif
    taken[0] = e0;
    taken[1] = e1;
    @(posedge clk);
    if (rst_req) begin
      if (idle) begin
        if (g >= 0) begin
          acc = (g == 0) ? ref_alu(1'b0, ra[0], rb[0], rop[0], rcin[0])
                         : ref_alu(1'b1, ra[1], rb[1], rop[1], rcin[1]);
          mq.push_back(acc);
          mdelay = 1;
          mlast = (g == 1);
          acc_log.push_back(g);
          acc_cyc.push_back(cyc);
          if (m_cnt[g] < 65535) m_cnt[g]++;
        end
      end else if (mdelay > 0) begin
        mdelay--;
      end else if (rr) begin
        void'(mq.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    rv[0] = 1'b0; rv[1] = 1'b0; rr = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[6];
    logic [7:0] snap_res;
    logic snap_id, snap_cout, snap_gt;
    exp_seq = '{0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0; rcin[i] = 1'b0; taken[i] = 1'b0;
    end
    model_reset();

    // Model pins against hand arithmetic.
    chk("model_add", 32'(ref_alu(1'b0, 8'h0F, 8'h01, 3'd0, 1'b0).res), 32'h10);
    chk("model_sub", 32'(ref_alu(1'b0, 8'h05, 8'h07, 3'd1, 1'b1).res), 32'hFE);
    chk("model_cmp", 32'(ref_alu(1'b1, 8'h09, 8'h03, 3'd5, 1'b0).gt), 32'h1);

    // Reset: readies low even with a valid request present.
    rst_req = 1'b0; rv[0] = 1'b1;
    cycle();
    chk("rst_ready0", 32'(o_rdy0), 32'h0);
    chk("rst_rsp_result", 32'(o_res), 32'h0);
    cycle();

    // req0 alone: 0x0F + 0x01.
    rst_req = 1'b1; ra[0] = 8'h0F; rb[0] = 8'h01; rop[0] = 3'd0; rcin[0] = 1'b0;
    cycle();
    chk("t1_ready0", 32'(o_rdy0), 32'h1);
    rv[0] = 1'b0;
    cycle();
    chk("t1_exec_no_rsp", 32'(o_rv), 32'h0);
    cycle();
    chk("t1_rsp_valid", 32'(o_rv), 32'h1);
    chk("t1_result", 32'(o_res), 32'h10);
    chk("t1_cout", 32'(o_cout), 32'h0);
    chk("t1_id", 32'(o_id), 32'h0);
    cycle();

    // Tie on the first cycle after reset: req0 first, then req1.
    rst_req = 1'b0;
    cycle();
    rst_req = 1'b1;
    rv[0] = 1'b1; ra[0] = 8'h05; rb[0] = 8'h07; rop[0] = 3'd1; rcin[0] = 1'b1;
    rv[1] = 1'b1; ra[1] = 8'h09; rb[1] = 8'h03; rop[1] = 3'd5; rcin[1] = 1'b0;
    cycle();
    chk("t2_ready0", 32'(o_rdy0), 32'h1);
    chk("t2_ready1", 32'(o_rdy1), 32'h0);
    rv[0] = 1'b0;
    cycle();
    cycle();
    chk("t2_rsp0_id", 32'(o_id), 32'h0);
    chk("t2_rsp0_result", 32'(o_res), 32'hFE);
    chk("t2_rsp0_cout", 32'(o_cout), 32'h0);
    cycle();
    chk("t2_ready1_next", 32'(o_rdy1), 32'h1);
    rv[1] = 1'b0;
    cycle();
    cycle();
    chk("t2_rsp1_id", 32'(o_id), 32'h1);
    chk("t2_rsp1_result", 32'(o_res), 32'h0);
    chk("t2_rsp1_gt", 32'(o_gt), 32'h1);

    // Sustained contention: six operations, alternating grants, one per three cycles.
    acc_log.delete(); acc_cyc.delete();
    taken[0] = 1'b1; taken[1] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (taken[i]) new_op(i);
        rv[i] = 1'b1;
      end
      cycle();
    end
    chk("t3_num_acc", 32'(acc_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < acc_log.size(); k++) begin
      chk("t3_grant_seq", 32'(acc_log[k]), 32'(exp_seq[k]));
      if (k > 0) chk("t3_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    end
    drain(2);

    // Back-pressure: five RESP cycles with rsp_ready low while req1 waits.
    rv[0] = 1'b1; new_op(0);
    cycle();
    rv[0] = 1'b0; rv[1] = 1'b1; new_op(1); rr = 1'b0;
    cycle();
    cycle();
    snap_res = o_res; snap_id = o_id; snap_cout = o_cout; snap_gt = o_gt;
    chk("t4_resp_valid", 32'(o_rv), 32'h1);
    chk("t4_ready1_held", 32'(o_rdy1), 32'h0);
    repeat (4) begin
      cycle();
      chk("t4_stable_res", 32'(o_res), 32'(snap_res));
      chk("t4_stable_id", 32'(o_id), 32'(snap_id));
      chk("t4_stable_flags", 32'({o_cout, o_gt}), 32'({snap_cout, snap_gt}));
      chk("t4_ready1_held", 32'(o_rdy1), 32'h0);
    end
    rr = 1'b1;
    cycle();
    cycle();
    chk("t4_ready1_after", 32'(o_rdy1), 32'h1);
    drain(4);

    // Reset one cycle after acceptance: operation discarded, pointer back to 1.
    rv[0] = 1'b1; new_op(0);
    cycle();
    rv[0] = 1'b0; rst_req = 1'b0;
    cycle();
    chk("t5_no_rsp", 32'(o_rv), 32'h0);
    cycle();
    chk("t5_rst_result", 32'(o_res), 32'h0);
    chk("t5_rst_id", 32'(o_id), 32'h0);
    chk("t5_rst_flags", 32'({o_cout, o_gt}), 32'h0);
    rst_req = 1'b1;
    rv[0] = 1'b1; rv[1] = 1'b1; new_op(0); new_op(1);
    cycle();
    chk("t5_tie_ready0", 32'(o_rdy0), 32'h1);
    chk("t5_tie_ready1", 32'(o_rdy1), 32'h0);
    drain(4);

    // Withdrawn request while busy: no grant and pointer untouched.
    rv[1] = 1'b1; new_op(1);
    cycle();
    rv[1] = 1'b0; rv[0] = 1'b1; new_op(0);
    cycle();
    rv[0] = 1'b0; rr = 1'b0;
    cycle();
    cycle();
    rr = 1'b1;
    cycle();
    rv[0] = 1'b1; rv[1] = 1'b1; new_op(0); new_op(1);
    cycle();
    chk("t6_tie_ready0", 32'(o_rdy0), 32'h1);
    drain(4);

    // Randomized traffic with occasional withdrawals and consumer stalls.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (taken[i]) rv[i] = 1'b0;
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          new_op(i);
          rv[i] = 1'b1;
        end else if (rv[i] && $urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(6);

`ifdef ALU_SCHED_STATS_EN
    rst_req = 1'b0;
    cycle();
    rst_req = 1'b1;
    taken[0] = 1'b1; taken[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (taken[i]) new_op(i);
        rv[i] = 1'b1;
      end
      cycle();
    end
    rv[1] = 1'b0; rv[0] = 1'b1; new_op(0);
    cycle();
    drain(4);
    chk("stats_cnt0", 32'(o_cnt0), 32'd3);
    chk("stats_cnt1", 32'(o_cnt1), 32'd2);
    force dut.ops0_cnt = 16'hFFFF;
    #1;
    release dut.ops0_cnt;
    m_cnt[0] = 65535;
    rv[0] = 1'b1; new_op(0);
    cycle();
    drain(4);
    chk("stats_saturate", 32'(o_cnt0), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
